// File: rtl/adder_pipe_pkg.sv
// Shared constants and helpers for the chunked pipelined adder.
// Chunk width is derived here so the top and any wrapper agree on it.
package adder_pipe_pkg;

  localparam int MIN_WIDTH = 2;

  function automatic int chunk_w(input int width, input int stages);
    return width / stages;
  endfunction

  // A legal configuration splits WIDTH into STAGES equal, non-empty chunks.
  function automatic bit cfg_legal(input int width, input int stages);
    return (width >= MIN_WIDTH) && (stages >= 1) && (stages <= width) &&
           ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// CHUNK-bit combinational ripple-carry adder; one instance per pipeline stage.
module adder_chunk
  import adder_pipe_pkg::*;
#(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    co = c[CHUNK];
  end

endmodule

// File: rtl/adder_pipe.sv
// Pipelined WIDTH-bit adder, one CHUNK-bit slice per stage with valid/ready flow.
// Optional ADDER_PIPE_OVF_EN adds a signed-overflow output aligned with sum.
module adder_pipe
  import adder_pipe_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             out_valid,
  input  logic             out_ready
`ifdef ADDER_PIPE_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CHUNK  = chunk_w(WIDTH, STAGES);
  localparam bit CFG_OK = cfg_legal(WIDTH, STAGES);

  generate
    if (!CFG_OK) begin : g_bad_cfg
      $error("adder_pipe: WIDTH must be >= 2 and divisible by STAGES");
    end
  endgenerate

  logic [STAGES-1:0]            vld_q, vld_d, ld, src_vld;
  logic [STAGES-1:0]            c_q, c_d, c_src, c_out;
  logic [STAGES-1:0][WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
  logic [STAGES-1:0][WIDTH-1:0] a_src, b_src, s_src;
  logic [STAGES-1:0][CHUNK-1:0] ch_s;

  // Load chain: a stage may load if it is empty or its contents move on
  // this cycle; ripples combinationally back from out_ready.
  always_comb begin
    ld = '0;
    ld[STAGES-1] = !vld_q[STAGES-1] || out_ready;
    for (int k = STAGES - 2; k >= 0; k--)
      ld[k] = !vld_q[k] || ld[k+1];
  end

  // Each stage is fed by the previous stage's skew registers.
  always_comb begin
    a_src      = '0;
    b_src      = '0;
    s_src      = '0;
    c_src      = '0;
    src_vld    = '0;
    a_src[0]   = a;
    b_src[0]   = b;
    c_src[0]   = ci;
    src_vld[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_src[k]   = a_q[k-1];
      b_src[k]   = b_q[k-1];
      s_src[k]   = s_q[k-1];
      c_src[k]   = c_q[k-1];
      src_vld[k] = vld_q[k-1];
    end
  end

  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      adder_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a  (a_src[k][k*CHUNK +: CHUNK]),
        .b  (b_src[k][k*CHUNK +: CHUNK]),
        .ci (c_src[k]),
        .s  (ch_s[k]),
        .co (c_out[k])
      );
    end
  endgenerate

  // Data registers only capture when a real transaction arrives, so empty
  // stages keep their contents frozen.
  always_comb begin
    vld_d = vld_q;
    a_d   = a_q;
    b_d   = b_q;
    s_d   = s_q;
    c_d   = c_q;
    for (int k = 0; k < STAGES; k++) begin
      if (ld[k]) vld_d[k] = src_vld[k];
      if (ld[k] && src_vld[k]) begin
        a_d[k] = a_src[k];
        b_d[k] = b_src[k];
        s_d[k] = s_src[k];
        s_d[k][k*CHUNK +: CHUNK] = ch_s[k];
        c_d[k] = c_out[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= '0;
      c_q   <= '0;
    end else begin
      vld_q <= vld_d;
      a_q   <= a_d;
      b_q   <= b_d;
      s_q   <= s_d;
      c_q   <= c_d;
    end
  end

  assign in_ready  = ld[0];
  assign out_valid = vld_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign co        = c_q[STAGES-1];

`ifdef ADDER_PIPE_OVF_EN
  assign ovf = (a_q[STAGES-1][WIDTH-1] == b_q[STAGES-1][WIDTH-1]) &&
               (s_q[STAGES-1][WIDTH-1] != a_q[STAGES-1][WIDTH-1]);
`endif

  // Last-stage operand copies only feed the optional overflow flag.
  logic unused_ops;
  assign unused_ops = ^{a_q[STAGES-1], b_q[STAGES-1]};

endmodule

// File: doc/adder_pipe.md
ADDER_PIPE -- requirements
Module: adder_pipe

Interface
REQ-001 Parameter WIDTH, default 16, operand/sum width in bits; SHALL be >= 2.
REQ-002 Parameter STAGES, default 4, number of pipeline stages; SHALL divide WIDTH exactly, with CHUNK = WIDTH/STAGES bits per stage.
REQ-003 Ports SHALL be: clk in 1 clock; rst_n in 1 reset.
REQ-004 One clock; reset is asynchronous and active-low (clk, rst_n).
REQ-005 Ports SHALL be: a in WIDTH operand; b in WIDTH operand; ci in 1 carry-in; in_valid in 1 operands valid; in_ready out 1 operands accepted.
REQ-006 Ports SHALL be: sum out WIDTH result; co out 1 carry-out; out_valid out 1 result valid; out_ready in 1 result consumed.
REQ-007 When ADDER_PIPE_OVF_EN is defined, port ovf out 1 (signed overflow) SHALL exist.

Function
REQ-008 Result SHALL be {co,sum} = a + b + ci, modulo 2^(WIDTH+1).
REQ-009 Stage k (0..STAGES-1) SHALL add chunk k of a and b plus the carry registered by stage k-1 (ci for stage 0), then register the chunk sum and the chunk carry.
REQ-010 Unconsumed upper operand chunks and finished lower sum chunks SHALL travel in skew registers alongside their transaction.
REQ-011 Input transfer occurs on in_valid && in_ready; output transfer occurs on out_valid && out_ready.
REQ-012 Each stage SHALL hold a valid bit; stage k SHALL load when empty or when stage k+1 loads in the same cycle; the last stage loads when empty or out_ready=1.
REQ-013 in_ready SHALL equal the stage-0 load condition (combinational from out_ready through the valid chain); no combinational path from in_valid to in_ready.
REQ-014 Latency with out_ready held 1 SHALL be exactly STAGES cycles, input transfer edge to out_valid high.
REQ-015 Throughput with out_ready held 1 SHALL be one transaction per cycle, with no bubbles inserted.
REQ-016 With out_ready=0, sum/co/out_valid SHALL hold stable; internal bubbles SHALL collapse, and the pipe SHALL accept until all STAGES slots are full.
REQ-017 Full pipe with out_ready 0->1: output transfer and new input acceptance SHALL occur in the same cycle.
REQ-018 Transactions SHALL never be dropped, duplicated or reordered.
REQ-019 Chunk registers of empty stages SHALL NOT toggle (load gated by in_valid/valid bits).

Reset
REQ-020 On rst_n low, all valid bits SHALL clear immediately; out_valid=0, sum=0, co=0, ovf=0.
REQ-021 in_ready SHALL be 1 while in reset and after release.
REQ-022 Reset mid-operation SHALL discard all in-flight transactions; no result of a pre-reset transaction appears after release.
REQ-023 Release of rst_n SHALL be usable one cycle later without extra synchronisation inside the block.

Configuration
REQ-024 Macro ADDER_PIPE_OVF_EN: when defined, ovf = signed overflow of a+b+ci (operand MSBs equal and sum MSB different), aligned with sum; when undefined, port and logic are absent and REQ-001..023 are unchanged.

Structure
REQ-025 Package adder_pipe_pkg SHALL hold the CHUNK computation function and the WIDTH%STAGES legality check constant.
REQ-026 Sub-module adder_chunk (parametrised CHUNK-bit combinational ripple add with carry in/out) SHALL be instantiated once per stage in a generate loop.

Verification (WIDTH=16, STAGES=4 unless stated)
REQ-027 a=16'hFFFF, b=16'h0001, ci=0, out_ready=1 -> 4 cycles later sum=16'h0000, co=1, out_valid for exactly one cycle (carry crosses every stage).
REQ-028 Back-to-back 8 random pairs, out_ready=1 -> 8 consecutive results, each matching the model, first at cycle 4.
REQ-029 out_ready=0, in_valid=1 held -> exactly 4 accepted then in_ready=0; raise out_ready -> 4 results in order, then accept resumes in the same cycle.
REQ-030 Transaction in stage 2, rst_n pulsed low -> out_valid=0 at once, no stale result after release, next input gives correct sum.
REQ-031 With ADDER_PIPE_OVF_EN: a=16'h7FFF, b=16'h0001, ci=0 -> sum=16'h8000, ovf=1; a=16'h8000, b=16'h8000 -> sum=0, co=1, ovf=1.
REQ-032 WIDTH=8, STAGES=1 and WIDTH=8, STAGES=8 -> exhaustive a, b, ci sweep matches the model, with latency 1 and 8 respectively.
